video_fb_timing: RTL and testbench
==================================

Name: video_fb_timing

Overview:
- Parametrised successor to the fixed 640x480 VGA/HDMI sync + 1-bit framebuffer block.
- Generates programmable h/v timing with selectable sync polarity.
- Reads a BPP-bit-per-pixel framebuffer and maps each pixel through a writable 24-bit palette.
- All outputs (sync, DE, RGB, frame pulse) are pipeline-aligned. Sits between the plotting engine (write side) and the HDMI transmitter.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
- HS_POL, 0, hsync active level
- VS_POL, 0, vsync active level
- X_BITS, 10, h counter / x address width; 2^X_BITS >= H_ACTIVE+H_FP+H_SYNC+H_BP
- Y_BITS, 10, v counter / y address width; 2^Y_BITS >= V total
- BPP, 4, bits per pixel (palette index width)

Ports:
- clock  in  1  pixel clock; all logic and both RAMs on this clock
- reset  in  1  asynchronous, active-high
- fb_we  in  1  framebuffer write strobe
- fb_x  in  X_BITS  write x
- fb_y  in  Y_BITS  write y
- fb_data  in  BPP  pixel index to store
- pal_we  in  1  palette write strobe
- pal_idx  in  BPP  palette entry
- pal_rgb  in  24  palette colour {R,G,B}
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- de  out  1  data enable
- rgb  out  24  pixel colour, 0 when de low
- frame_start  out  1  one-clock pulse aligned with output pixel (0,0)

Behaviour:
- Derived totals: HT = H_ACTIVE+H_FP+H_SYNC+H_BP; VT = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Stage 0 counters:
  - h counts 0..HT-1, then wraps to 0.
  - v increments when h wraps; v wraps VT-1 -> 0 on the same edge that h wraps.
- Stage 0 decode:
  - act = (h < H_ACTIVE) && (v < V_ACTIVE).
  - hs = h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vs = v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), evaluated on the v value only (full lines).
  - fs = (h==0 && v==0).
- Framebuffer:
  - Depth 2^(X_BITS+Y_BITS) x BPP, address {y,x}.
  - Read address = {v,h} from stage 0; registered read gives data in stage 1.
- Palette:
  - 2^BPP x 24, registered read of the stage-1 index gives colour in stage 2.
- Stage 3 output registers:
  - rgb = act ? colour : 0.
  - hsync = hs ? HS_POL : ~HS_POL; vsync likewise with VS_POL.
  - de = act; frame_start = fs.
  - act/hs/vs/fs are delayed through matching stages.
- Latency: exactly 3 clocks from counter value to outputs. No skew between rgb and de/sync.
- Writes:
  - fb_we stores fb_data at {fb_y,fb_x} on the rising edge.
  - Writes with fb_x >= H_ACTIVE or fb_y >= V_ACTIVE are ignored.
  - Read/write to the same address in the same cycle returns the old data (read-first).
- Palette writes:
  - pal_we stores pal_rgb at pal_idx.
  - A same-cycle lookup of the same index returns the old colour.
  - Update is visible to lookups from the following clock.
- Simultaneous fb_we and pal_we are both performed.
- Reset:
  - Counters h=0, v=0; all pipeline stages cleared.
  - Outputs: hsync=~HS_POL, vsync=~VS_POL, de=0, rgb=0, frame_start=0.
  - RAM and palette contents are not affected by reset.
  - Reset mid-frame restarts at (0,0).
  - After reset release: de, frame_start and rgb of pixel (0,0) appear after the 3rd rising edge.
- Power-up palette contents: entry 0 = 24'h000000, all others = 24'hFFFFFF. This gives backward-compatible 1-bit black/white.
- Framebuffer power-up contents: 0.

Test Plan:
- Bench parameters: H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=3 (HT=16); V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1 (VT=8); BPP=2; X_BITS=4; Y_BITS=3; HS_POL=VS_POL=0.
- Timing: run 2 frames after reset.
  - de high 8 of every 16 clocks on lines 0..3 only.
  - hsync low 3 clocks, starting 10 clocks after the de rising edge.
  - vsync low for 32 clocks (lines 5-6).
  - frame_start pulses every 128 clocks, coincident with the first de high.
- Pixel path:
  - Write fb(3,2)=2, pal[2]=24'h00FF00, all other pixels 0.
  - Required: rgb=24'h00FF00 exactly on the output cycle with de high at x=3, y=2; 0 elsewhere.
  - The out-of-range write fb(9,1)=3 leaves output unchanged.
- Default palette: write fb(0,0)=1 with no palette writes -> rgb=24'hFFFFFF on the frame_start cycle.
- Collision:
  - Write pal[1]=24'h123456 on the same clock the pipeline looks up index 1 -> old colour is output for that pixel.
  - 24'h123456 is output for the next pixel of index 1.
- Reset mid-frame:
  - Assert reset asynchronously at line 2, x=5, for 2 clocks.
  - Outputs go to idle values immediately, without waiting for a clock edge.
  - After release, frame_start occurs after the 3rd edge, and framebuffer/palette contents are preserved.
- Polarity: HS_POL=1, VS_POL=1 build -> hsync/vsync idle low, high only during the sync windows.

Source files
------------

// File: rtl/video_fb_timing.sv
// Video scan-out: programmable h/v timing, BPP-bit framebuffer and writable 24-bit palette.
// Every output is registered three clocks after the counter value it belongs to.
module video_fb_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int X_BITS   = 10,
  parameter int Y_BITS   = 10,
  parameter int BPP      = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fb_we,
  input  logic [X_BITS-1:0] fb_x,
  input  logic [Y_BITS-1:0] fb_y,
  input  logic [BPP-1:0]    fb_data,
  input  logic              pal_we,
  input  logic [BPP-1:0]    pal_idx,
  input  logic [23:0]       pal_rgb,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic [23:0]       rgb,
  output logic              frame_start
);
  localparam int HT       = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT       = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int FB_AW    = X_BITS + Y_BITS;
  localparam int PAL_N    = 2 ** BPP;
  localparam logic [X_BITS-1:0] H_LAST = X_BITS'(HT - 1);
  localparam logic [Y_BITS-1:0] V_LAST = Y_BITS'(VT - 1);

  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
    logic fs;
  } side_t;

  logic [X_BITS-1:0] h_q, h_d;
  logic [Y_BITS-1:0] v_q, v_d;
  side_t             side0, side1_q, side2_q;
  logic [BPP-1:0]    idx1_q;
  logic [23:0]       col2_q;
  logic              hsync_q, hsync_d;
  logic              vsync_q, vsync_d;
  logic              de_q, de_d;
  logic              fs_q, fs_d;
  logic [23:0]       rgb_q, rgb_d;
  logic              fb_wr_ok;

  logic [BPP-1:0]    fb_mem  [2**FB_AW];
  logic [23:0]       pal_mem [PAL_N];

  // Palette RAM holds colour XOR its power-up default, so all-zero RAM reads
  // back as entry 0 black and every other entry white.
  function automatic logic [23:0] pal_dflt(input logic [BPP-1:0] i);
    return (i == '0) ? 24'h000000 : 24'hFFFFFF;
  endfunction

  // Stage 0: scan counters
  always_comb begin
    h_d = h_q + 1'b1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end
  end

  always_comb begin
    side0     = '0;
    side0.act = (int'(h_q) < H_ACTIVE) && (int'(v_q) < V_ACTIVE);
    side0.hs  = (int'(h_q) >= HS_START) && (int'(h_q) < HS_END);
    side0.vs  = (int'(v_q) >= VS_START) && (int'(v_q) < VS_END);
    side0.fs  = (h_q == '0) && (v_q == '0);
  end

  // Framebuffer: read-first, writes outside the visible area dropped
  assign fb_wr_ok = fb_we && (int'(fb_x) < H_ACTIVE) && (int'(fb_y) < V_ACTIVE);

  always_ff @(posedge clock) begin
    if (fb_wr_ok) fb_mem[{fb_y, fb_x}] <= fb_data;
    idx1_q <= fb_mem[{v_q, h_q}];
  end

  // Palette: read-first, new colour visible to lookups from the next clock
  always_ff @(posedge clock) begin
    if (pal_we) pal_mem[pal_idx] <= pal_rgb ^ pal_dflt(pal_idx);
    col2_q <= pal_mem[idx1_q] ^ pal_dflt(idx1_q);
  end

  // Stage 3 output decode
  always_comb begin
    rgb_d   = side2_q.act ? col2_q : 24'h000000;
    hsync_d = side2_q.hs ? HS_POL : ~HS_POL;
    vsync_d = side2_q.vs ? VS_POL : ~VS_POL;
    de_d    = side2_q.act;
    fs_d    = side2_q.fs;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h_q     <= '0;
      v_q     <= '0;
      side1_q <= '0;
      side2_q <= '0;
      hsync_q <= ~HS_POL;
      vsync_q <= ~VS_POL;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
      rgb_q   <= '0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      side1_q <= side0;
      side2_q <= side1_q;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      fs_q    <= fs_d;
      rgb_q   <= rgb_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign rgb         = rgb_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_video_fb_timing.sv
// Bench for video_fb_timing: small 16x8 raster, scoreboard of expected outputs
// plus a second instance built with active-high sync polarity.
module tb_video_fb_timing;
  localparam int XB = 4;
  localparam int YB = 3;
  localparam int BW = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          fb_we = 1'b0;
  logic [XB-1:0] fb_x = '0;
  logic [YB-1:0] fb_y = '0;
  logic [BW-1:0] fb_data = '0;
  logic          pal_we = 1'b0;
  logic [BW-1:0] pal_idx = '0;
  logic [23:0]   pal_rgb = '0;
  logic          hsync, vsync, de, frame_start;
  logic [23:0]   rgb;
  logic          hsync_p, vsync_p, de_p, fs_p;
  logic [23:0]   rgb_p;

  always #5 clock = ~clock;

  video_fb_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .X_BITS(XB), .Y_BITS(YB), .BPP(BW)
  ) dut (
    .clock(clock), .reset(reset),
    .fb_we(fb_we), .fb_x(fb_x), .fb_y(fb_y), .fb_data(fb_data),
    .pal_we(pal_we), .pal_idx(pal_idx), .pal_rgb(pal_rgb),
    .hsync(hsync), .vsync(vsync), .de(de), .rgb(rgb), .frame_start(frame_start)
  );

  video_fb_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .X_BITS(XB), .Y_BITS(YB), .BPP(BW)
  ) dut_p (
    .clock(clock), .reset(reset),
    .fb_we(1'b0), .fb_x(4'd0), .fb_y(3'd0), .fb_data(2'd0),
    .pal_we(1'b0), .pal_idx(2'd0), .pal_rgb(24'd0),
    .hsync(hsync_p), .vsync(vsync_p), .de(de_p), .rgb(rgb_p), .frame_start(fs_p)
  );

  typedef struct {
    bit          act, hs, vs, fs;
    int          x, y;
    logic [1:0]  idx;
    logic [23:0] rgb;
  } exp_t;

  exp_t        sb[$];
  exp_t        pend, last_e, idle_e;
  logic [1:0]  mfb [128];
  logic [23:0] mpal [4];
  int          mh, mv, ntests, nfail, tcount, last_fs, green_cnt;
  bit          have_fs, found;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_hsync"}, 32'(hsync), 32'd1);
    chk({tag, "_vsync"}, 32'(vsync), 32'd1);
    chk({tag, "_de"}, 32'(de), 32'd0);
    chk({tag, "_rgb"}, 32'(rgb), 32'd0);
    chk({tag, "_fs"}, 32'(frame_start), 32'd0);
    chk({tag, "_hsync_pol"}, 32'(hsync_p), 32'd0);
    chk({tag, "_vsync_pol"}, 32'(vsync_p), 32'd0);
  endtask

  task automatic model_reset();
    idle_e.act = 0; idle_e.hs = 0; idle_e.vs = 0; idle_e.fs = 0;
    idle_e.x = -1; idle_e.y = -1; idle_e.idx = '0; idle_e.rgb = '0;
    pend = idle_e;
    sb.delete();
    sb.push_back(idle_e);
    mh = 0; mv = 0; have_fs = 0;
  endtask

  // One pixel clock: update the model at the rising edge, compare at the falling edge.
  task automatic tick();
    exp_t e, r;
    @(posedge clock);
    tcount++;
    r = pend;
    r.rgb = pend.act ? mpal[pend.idx] : 24'h0;
    sb.push_back(r);
    pend.act = (mh < 8) && (mv < 4);
    pend.hs  = (mh >= 10) && (mh < 13);
    pend.vs  = (mv >= 5) && (mv < 7);
    pend.fs  = (mh == 0) && (mv == 0);
    pend.x   = mh;
    pend.y   = mv;
    pend.idx = mfb[mv * 16 + mh];
    mh++;
    if (mh == 16) begin
      mh = 0;
      mv = (mv == 7) ? 0 : mv + 1;
    end
    if (fb_we && fb_x < 8 && fb_y < 4) mfb[int'(fb_y) * 16 + int'(fb_x)] = fb_data;
    if (pal_we) mpal[pal_idx] = pal_rgb;
    @(negedge clock);
    e = sb.pop_front();
    last_e = e;
    chk("de", 32'(de), 32'(e.act));
    chk("hsync", 32'(hsync), 32'(!e.hs));
    chk("vsync", 32'(vsync), 32'(!e.vs));
    chk("frame_start", 32'(frame_start), 32'(e.fs));
    chk("rgb", 32'(rgb), 32'(e.rgb));
    chk("hsync_pol", 32'(hsync_p), 32'(e.hs));
    chk("vsync_pol", 32'(vsync_p), 32'(e.vs));
    chk("de_pol", 32'(de_p), 32'(e.act));
    chk("rgb_pol", 32'(rgb_p), 32'd0);
    if (de && rgb == 24'h00FF00) green_cnt++;
    if (frame_start) begin
      if (have_fs) chk("fs_period", 32'(tcount - last_fs), 32'd128);
      have_fs = 1;
      last_fs = tcount;
    end
  endtask

  task automatic wr_fb(input int x, input int y, input int d);
    fb_we = 1'b1; fb_x = XB'(x); fb_y = YB'(y); fb_data = BW'(d);
    tick();
    fb_we = 1'b0;
  endtask

  task automatic wr_pal(input int i, input logic [23:0] c);
    pal_we = 1'b1; pal_idx = BW'(i); pal_rgb = c;
    tick();
    pal_we = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mfb[i] = '0;
    mpal[0] = 24'h000000;
    for (int i = 1; i < 4; i++) mpal[i] = 24'hFFFFFF;
    ntests = 0; nfail = 0; tcount = 0; last_fs = 0; green_cnt = 0;
    model_reset();

    repeat (2) @(posedge clock);
    #1 chk_idle("reset");
    @(negedge clock);
    reset = 1'b0;

    // Pixel path, out-of-range write, default palette setup
    wr_fb(3, 2, 2);
    wr_fb(9, 1, 3);
    wr_fb(0, 0, 1);
    wr_pal(2, 24'h00FF00);
    repeat (252) tick();
    chk("green_hits", 32'(green_cnt), 32'd2);

    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (frame_start) found = 1;
    end
    chk("fs_found", 32'(found), 32'd1);
    chk("default_pal", 32'(rgb), 32'h00FFFFFF);

    // Palette write colliding with the lookup of pixel (5,1)
    wr_fb(5, 1, 1);
    wr_fb(6, 1, 1);
    for (int i = 0; i < 200 && !(mh == 6 && mv == 1); i++) tick();
    chk("reach_6_1", 32'(mh == 6 && mv == 1), 32'd1);
    wr_pal(1, 24'h123456);
    for (int i = 0; i < 20 && !(last_e.x == 5 && last_e.y == 1); i++) tick();
    chk("collision_old", 32'(rgb), 32'h00FFFFFF);
    tick();
    chk("collision_new", 32'(rgb), 32'h00123456);

    // Asynchronous reset mid-frame
    for (int i = 0; i < 200 && !(mh == 5 && mv == 2); i++) tick();
    chk("reach_5_2", 32'(mh == 5 && mv == 2), 32'd1);
    chk("pre_rst_de", 32'(de), 32'd1);
    #2 reset = 1'b1;
    #1 chk_idle("async_rst");
    model_reset();
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    chk_idle("rst_hold");
    reset = 1'b0;
    tick();
    chk("fs_edge1", 32'(frame_start), 32'd0);
    tick();
    chk("fs_edge2", 32'(frame_start), 32'd0);
    tick();
    chk("fs_edge3", 32'(frame_start), 32'd1);
    chk("rgb_kept", 32'(rgb), 32'h00123456);
    repeat (140) tick();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
